// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piso_pkg
//  Description : Shared types and helpers for the PISO serializer: the
//                two-state FSM encoding and the frame-length function.
//  Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

    // IDLE: no frame held. SHIFT: frame held, bits still pending.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Number of serial bits per frame: the data bits plus an optional parity bit.
    function automatic int frame_len(input int width, input bit parity_en);
        return parity_en ? (width + 1) : width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : piso_bit_counter
//  Description : Bits-remaining counter for the PISO serializer. Loads the
//                frame length, decrements once per consumed bit, saturates
//                at zero and flags when exactly one bit is left.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_bit_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_value,
    input  logic             i_dec_en,
    output logic             o_is_one
);

    logic [CNT_W-1:0] r_count;

    // Load has priority over decrement; a count of zero never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec_en && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_is_one = (r_count == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer
//  Description : Parallel-in / serial-out serializer with valid/ready
//                handshakes on both sides and back-to-back frame support.
//                Build option PISO_PARITY_EN appends an even-parity bit
//                (XOR of the data word) after the data bits; that bit then
//                carries ser_last.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] par_data,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);

`ifdef PISO_PARITY_EN
    localparam bit c_parity_en = 1'b1;
`else
    localparam bit c_parity_en = 1'b0;
`endif

    localparam int c_flen  = frame_len(WIDTH, c_parity_en);
    localparam int c_cnt_w = $clog2(c_flen + 1);

    state_t             r_state;
    logic [c_flen-1:0]  r_shreg;
    logic [c_flen-1:0]  w_load_word;
    logic [c_flen-1:0]  w_shift_word;
    logic [c_cnt_w-1:0] w_cnt_load;
    logic               w_out_bit;
    logic               w_cnt_is_one;
    logic               w_load_acc;
    logic               w_consume;

    assign w_cnt_load = c_cnt_w'(c_flen);

    // The output end of the shift register is bit 0 for LSB-first and the
    // top bit for MSB-first. With parity, the parity bit sits at the far end
    // so it leaves after every data bit.
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_shift_word = {1'b0, r_shreg[c_flen-1:1]};
            assign w_out_bit    = r_shreg[0];
`ifdef PISO_PARITY_EN
            assign w_load_word  = {^par_data, par_data};
`else
            assign w_load_word  = par_data;
`endif
        end else begin : g_msb_first
            assign w_shift_word = {r_shreg[c_flen-2:0], 1'b0};
            assign w_out_bit    = r_shreg[c_flen-1];
`ifdef PISO_PARITY_EN
            assign w_load_word  = {par_data, ^par_data};
`else
            assign w_load_word  = par_data;
`endif
        end
    endgenerate

    // Handshake decode. load_ready is forced low for as long as rst is held.
    assign ser_valid  = (r_state == SHIFT);
    assign busy       = (r_state == SHIFT);
    assign ser_last   = ser_valid & w_cnt_is_one;
    assign ser_out    = ser_valid & w_out_bit;
    assign load_ready = rst & ((r_state == IDLE) | (ser_last & ser_ready));
    assign w_load_acc = load_valid & load_ready;
    assign w_consume  = ser_valid & ser_ready;

    // FSM and shift register: a load (including one on the last-bit edge)
    // wins over a shift; consuming the last bit alone returns to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_shreg <= '0;
        end else if (w_load_acc) begin
            r_state <= SHIFT;
            r_shreg <= w_load_word;
        end else if (w_consume) begin
            r_shreg <= w_shift_word;
            if (w_cnt_is_one) begin
                r_state <= IDLE;
            end
        end
    end

    piso_bit_counter #(
        .CNT_W (c_cnt_w)
    ) u_bit_counter (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load_acc),
        .i_load_value (w_cnt_load),
        .i_dec_en     (w_consume & ~w_load_acc),
        .o_is_one     (w_cnt_is_one)
    );

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_serializer
//  Description : Self-checking bench for piso_serializer. Two instances
//                (LSB-first and MSB-first) share one stimulus stream; a
//                queue-based model of the pending frame bits predicts every
//                output cycle by cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic [7:0] par_data;
    logic       ser_ready;

    logic lr_l, so_l, sv_l, sl_l, bz_l;
    logic lr_m, so_m, sv_m, sl_m, bz_m;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: bits still to be emitted, front = bit currently on ser_out.
    bit q_l[$];
    bit q_m[$];
    bit m_acc;

    // Observation helpers for directed literal checks.
    logic [15:0] cap_l, cap_m;
    int          ncap;
    int          nvalid;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1)) dut_lsb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(lr_l),
        .par_data(par_data), .ser_out(so_l), .ser_valid(sv_l),
        .ser_ready(ser_ready), .ser_last(sl_l), .busy(bz_l)
    );

    piso_serializer #(.WIDTH(8), .LSB_FIRST(0)) dut_msb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(lr_m),
        .par_data(par_data), .ser_out(so_m), .ser_valid(sv_m),
        .ser_ready(ser_ready), .ser_last(sl_m), .busy(bz_m)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_one(input string name, input logic lr, input logic so,
                             input logic sv, input logic sl, input logic bz,
                             input logic [63:0] cnt, input bit q[$]);
        int   sz;
        logic ev, eo, el, elr;
        sz  = q.size();
        ev  = (sz > 0);
        eo  = ev ? q[0] : 1'b0;
        el  = (sz == 1);
        elr = rst && ((sz == 0) || ((sz == 1) && ser_ready));
        chk({name, ".ser_valid"},  {63'd0, sv},  {63'd0, ev});
        chk({name, ".ser_out"},    {63'd0, so},  {63'd0, eo});
        chk({name, ".ser_last"},   {63'd0, sl},  {63'd0, el});
        chk({name, ".busy"},       {63'd0, bz},  {63'd0, ev});
        chk({name, ".load_ready"}, {63'd0, lr},  {63'd0, elr});
        chk({name, ".count"},      cnt,          64'(sz));
    endtask

    // One clock: check pre-edge outputs, advance the model, pass the edge.
    task automatic step_cycle();
        int sz;
        #1;
        if (!rst) begin
            q_l.delete();
            q_m.delete();
        end
        check_one("lsb", lr_l, so_l, sv_l, sl_l, bz_l, 64'(dut_lsb.u_bit_counter.r_count), q_l);
        check_one("msb", lr_m, so_m, sv_m, sl_m, bz_m, 64'(dut_msb.u_bit_counter.r_count), q_m);
        if (sv_l === 1'b1) nvalid++;
        sz    = q_l.size();
        m_acc = rst && load_valid && ((sz == 0) || ((sz == 1) && ser_ready));
        if (rst && (sz > 0) && ser_ready) begin
            cap_l = {so_l, cap_l[15:1]};
            cap_m = {cap_m[14:0], so_m};
            ncap++;
        end
        if (m_acc) begin
            q_l.delete();
            q_m.delete();
            for (int i = 0; i < 8; i++) q_l.push_back(par_data[i]);
            for (int i = 7; i >= 0; i--) q_m.push_back(par_data[i]);
`ifdef PISO_PARITY_EN
            q_l.push_back(^par_data);
            q_m.push_back(^par_data);
`endif
        end else if (rst && (sz > 0) && ser_ready) begin
            void'(q_l.pop_front());
            void'(q_m.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        cap_l  = '0;
        cap_m  = '0;
        ncap   = 0;
        nvalid = 0;
    endtask

    initial begin
        int k;
        rst        = 1'b1;
        load_valid = 1'b0;
        par_data   = 8'h00;
        ser_ready  = 1'b1;
        clear_obs();
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset state: everything low, including load_ready.
        repeat (2) step_cycle();
        chk("reset.load_ready", {63'd0, lr_l}, 64'd0);

        // Release: load_ready must come back at once.
        rst = 1'b1;
        step_cycle();

        // Single frame 0xC1, downstream always ready.
        clear_obs();
        load_valid = 1'b1; par_data = 8'hC1;
        step_cycle();
        load_valid = 1'b0; par_data = 8'h00;
        repeat (9) step_cycle();
`ifndef PISO_PARITY_EN
        chk("c1.lsb_order", {48'd0, cap_l[15:8], 8'd0}, {48'd0, 8'hC1, 8'd0});
        chk("c1.msb_order", {56'd0, cap_m[7:0]}, 64'h0000_0000_0000_00C1);
        chk("c1.nbits", 64'(ncap), 64'd8);
        chk("c1.valid_cycles", 64'(nvalid), 64'd8);
`endif

        // Stall after bit 2 for three cycles.
        clear_obs();
        load_valid = 1'b1; par_data = 8'hC1;
        step_cycle();
        load_valid = 1'b0;
        repeat (2) step_cycle();
        ser_ready = 1'b0;
        repeat (3) step_cycle();
        ser_ready = 1'b1;
        repeat (7) step_cycle();
`ifndef PISO_PARITY_EN
        chk("stall.valid_cycles", 64'(nvalid), 64'd11);
        chk("stall.lsb_order", {48'd0, cap_l[15:8], 8'd0}, {48'd0, 8'hC1, 8'd0});
`endif

        // Back-to-back: 0x3C waits on load_valid until 0xC1's last bit.
        clear_obs();
        load_valid = 1'b1; par_data = 8'hC1;
        step_cycle();
        par_data = 8'h3C;
        k = 0;
        do begin
            step_cycle();
            k++;
        end while (!m_acc && k < 20);
        load_valid = 1'b0;
        repeat (9) step_cycle();
`ifndef PISO_PARITY_EN
        chk("b2b.accept_delay", 64'(k), 64'd8);
        chk("b2b.lsb_bits", {48'd0, cap_l}, {48'd0, 16'h3CC1});
        chk("b2b.msb_bits", {48'd0, cap_m}, {48'd0, 16'hC13C});
        chk("b2b.valid_cycles", 64'(nvalid), 64'd16);
`endif

        // Reset mid-frame after 4 bits of 0xFF.
        load_valid = 1'b1; par_data = 8'hFF;
        step_cycle();
        load_valid = 1'b0;
        repeat (4) step_cycle();
        rst = 1'b0;
        step_cycle();
        chk("midrst.ser_out", {63'd0, so_l}, 64'd0);
        step_cycle();
        rst = 1'b1;
        repeat (3) step_cycle();
        chk("postrst.ser_valid", {63'd0, sv_l}, 64'd0);
        chk("postrst.load_ready", {63'd0, lr_l}, 64'd1);

`ifdef PISO_PARITY_EN
        // Parity: 0x07 has odd weight -> parity 1; 0x03 even weight -> 0.
        clear_obs();
        load_valid = 1'b1; par_data = 8'h07;
        step_cycle();
        load_valid = 1'b0;
        repeat (10) step_cycle();
        chk("par07.bit", {63'd0, cap_l[15]}, 64'd1);
        chk("par07.nbits", 64'(ncap), 64'd9);
        clear_obs();
        load_valid = 1'b1; par_data = 8'h03;
        step_cycle();
        load_valid = 1'b0;
        repeat (10) step_cycle();
        chk("par03.bit", {63'd0, cap_l[15]}, 64'd0);
`endif

        // Randomized traffic with occasional resets.
        repeat (400) begin
            load_valid = 1'($urandom_range(0, 1));
            par_data   = 8'($urandom);
            ser_ready  = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 99) != 0);
            step_cycle();
        end
        rst = 1'b1;
        load_valid = 1'b0;
        ser_ready  = 1'b1;
        repeat (12) step_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
